// File: rtl/eth_frame_ctrl.sv
// eth_frame_ctrl - command sequencer for the iob_eth CPU register interface.
//
// Runs INIT / SEND / RECV sequences against the iob_eth register bus so the
// CPU only issues one command and waits for done.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/cmd_op_i    command request (0=INIT 1=SEND 2=RECV 3=illegal)
//   cmd_nbytes_i            payload length for SEND/RECV
//   cmd_ready_o, busy_o     idle / command in progress
//   done_o, status_o        end pulse, result (0=OK 1=INIT_FAIL 2=TIMEOUT 3=BAD_CMD)
//   pl_raddr_o/pl_rdata_i   payload RAM read port (1-cycle latency)
//   pl_waddr_o/pl_wdata_o/pl_we_o  payload RAM write port
//   eth_sel_o/eth_we_o/eth_addr_o/eth_data_in_o/eth_data_out_i  iob_eth bus
//
// Optional feature: define ETH_CTRL_RX_TIMEOUT_EN to make RECV give up with
// status=2 after RX_TIMEOUT status reads without the RX-ready bit.

`ifndef ETH_ADDR_W
`define ETH_ADDR_W 12
`endif
`ifndef ETH_STATUS
`define ETH_STATUS 0
`endif
`ifndef ETH_SEND
`define ETH_SEND 1
`endif
`ifndef ETH_RCVACK
`define ETH_RCVACK 2
`endif
`ifndef ETH_SOFTRST
`define ETH_SOFTRST 4
`endif
`ifndef ETH_DUMMY
`define ETH_DUMMY 5
`endif
`ifndef ETH_TX_NBYTES
`define ETH_TX_NBYTES 6
`endif
`ifndef ETH_RX_NBYTES
`define ETH_RX_NBYTES 7
`endif
`ifndef ETH_DATA
`define ETH_DATA 2048
`endif
`ifndef ETH_MAC_ADDR
`define ETH_MAC_ADDR 48'h0123_4567_89AB
`endif
`ifndef ETH_RMAC_ADDR
`define ETH_RMAC_ADDR 48'h001B_213C_4D5E
`endif

module eth_frame_ctrl #(
  parameter int          ETH_ADDR_W = `ETH_ADDR_W,
  parameter logic [47:0] DST_MAC    = `ETH_RMAC_ADDR,
  parameter logic [47:0] SRC_MAC    = `ETH_MAC_ADDR,
  parameter int          NB_W       = 11,
`ifdef ETH_CTRL_RX_TIMEOUT_EN
  parameter int          RX_TIMEOUT = 5000,
`endif
  parameter int          NBYTES_MAX = 1500
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  input  logic [1:0]            cmd_op_i,
  input  logic [NB_W-1:0]       cmd_nbytes_i,
  output logic                  cmd_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [NB_W-1:0]       pl_raddr_o,
  input  logic [7:0]            pl_rdata_i,
  output logic [NB_W-1:0]       pl_waddr_o,
  output logic [7:0]            pl_wdata_o,
  output logic                  pl_we_o,
  output logic                  eth_sel_o,
  output logic                  eth_we_o,
  output logic [ETH_ADDR_W-1:0] eth_addr_o,
  output logic [31:0]           eth_data_in_o,
  input  logic [31:0]           eth_data_out_i
);

  localparam logic [ETH_ADDR_W-1:0] A_STATUS = ETH_ADDR_W'(`ETH_STATUS);
  localparam logic [ETH_ADDR_W-1:0] A_SEND   = ETH_ADDR_W'(`ETH_SEND);
  localparam logic [ETH_ADDR_W-1:0] A_RCVACK = ETH_ADDR_W'(`ETH_RCVACK);
  localparam logic [ETH_ADDR_W-1:0] A_SRST   = ETH_ADDR_W'(`ETH_SOFTRST);
  localparam logic [ETH_ADDR_W-1:0] A_DUMMY  = ETH_ADDR_W'(`ETH_DUMMY);
  localparam logic [ETH_ADDR_W-1:0] A_TXN    = ETH_ADDR_W'(`ETH_TX_NBYTES);
  localparam logic [ETH_ADDR_W-1:0] A_RXN    = ETH_ADDR_W'(`ETH_RX_NBYTES);
  localparam logic [ETH_ADDR_W-1:0] A_DATA   = ETH_ADDR_W'(`ETH_DATA);
  localparam logic [31:0]           DUMMY_V  = 32'hDEAD_BEEF;
  localparam logic [NB_W-1:0]       NB_MIN   = NB_W'(46);
  localparam logic [NB_W-1:0]       NB_MAX   = NB_W'(NBYTES_MAX);

  typedef enum logic [4:0] {
    S_IDLE, S_RST_HI, S_RST_LO, S_POLL_RXCLK, S_POLL_PLL, S_INI_TXN, S_INI_RXN,
    S_DUMMY_WR, S_DUMMY_RD, S_TX_POLL, S_TX_LEN, S_TX_HDR, S_TX_PL, S_TX_GO,
    S_RX_LEN, S_RX_POLL, S_RX_DATA, S_RX_ACK, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            ph_q, ph_d;          // bus-read / RAM-read phase within a state
  logic [NB_W-1:0] cnt_q, cnt_d;        // header index or payload byte index
  logic [NB_W-1:0] nb_q, nb_d;
  logic [1:0]      status_q, status_d;
  logic            init_ok_q, init_ok_d;
`ifdef ETH_CTRL_RX_TIMEOUT_EN
  logic [31:0]     to_q, to_d;          // completed RX status reads
`endif

  logic last_byte;
  logic nb_ok;
  assign last_byte = (cnt_q == nb_q - NB_W'(1));
  assign nb_ok     = (cmd_nbytes_i >= NB_MIN) && (cmd_nbytes_i <= NB_MAX);

  // Frame header: preamble, SFD, destination MAC, source MAC, ethertype 0x0800.
  function automatic logic [7:0] hdr_byte(input logic [4:0] i);
    int          n;
    logic [47:0] sh;
    n  = int'(i);
    sh = '0;
    hdr_byte = 8'h55;
    if (n == 15) hdr_byte = 8'hD5;
    else if (n >= 16 && n <= 21) begin
      sh = DST_MAC >> (8 * (21 - n));
      hdr_byte = sh[7:0];
    end else if (n >= 22 && n <= 27) begin
      sh = SRC_MAC >> (8 * (27 - n));
      hdr_byte = sh[7:0];
    end else if (n == 28) hdr_byte = 8'h08;
    else if (n == 29) hdr_byte = 8'h00;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ph_q      <= 1'b0;
      cnt_q     <= '0;
      nb_q      <= '0;
      status_q  <= 2'd0;
      init_ok_q <= 1'b0;
`ifdef ETH_CTRL_RX_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      nb_q      <= nb_d;
      status_q  <= status_d;
      init_ok_q <= init_ok_d;
`ifdef ETH_CTRL_RX_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    cnt_d         = cnt_q;
    nb_d          = nb_q;
    status_d      = status_q;
    init_ok_d     = init_ok_q;
`ifdef ETH_CTRL_RX_TIMEOUT_EN
    to_d          = to_q;
`endif
    cmd_ready_o   = 1'b0;
    busy_o        = (state_q != S_IDLE);
    done_o        = 1'b0;
    status_o      = 2'd0;
    pl_raddr_o    = '0;
    pl_waddr_o    = '0;
    pl_wdata_o    = 8'h00;
    pl_we_o       = 1'b0;
    eth_sel_o     = 1'b0;
    eth_we_o      = 1'b0;
    eth_addr_o    = '0;
    eth_data_in_o = 32'h0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          nb_d  = cmd_nbytes_i;
          cnt_d = '0;
          ph_d  = 1'b0;
`ifdef ETH_CTRL_RX_TIMEOUT_EN
          to_d  = '0;
`endif
          // Illegal requests finish with BAD_CMD and never touch the bus.
          status_d = 2'd3;
          state_d  = S_DONE;
          case (cmd_op_i)
            2'd0: state_d = S_RST_HI;
            2'd1: if (nb_ok && init_ok_q) state_d = S_TX_POLL;
            2'd2: if (nb_ok && init_ok_q) state_d = S_RX_LEN;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_RST_HI: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_SRST;
        eth_data_in_o = 32'd1;
        state_d       = S_RST_LO;
      end
      S_RST_LO: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_SRST;
        eth_data_in_o = 32'd0;
        state_d       = S_POLL_RXCLK;
      end
      S_POLL_RXCLK, S_POLL_PLL, S_TX_POLL, S_RX_POLL: begin
        // Two-cycle status read: select, then sample with select low.
        if (!ph_q) begin
          eth_sel_o  = 1'b1;
          eth_addr_o = A_STATUS;
          ph_d       = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (state_q == S_POLL_RXCLK) begin
            if (eth_data_out_i[3]) state_d = S_POLL_PLL;
          end else if (state_q == S_POLL_PLL) begin
            if (eth_data_out_i[15]) state_d = S_INI_TXN;
          end else if (state_q == S_TX_POLL) begin
            if (eth_data_out_i[0]) state_d = S_TX_LEN;
          end else begin
            if (eth_data_out_i[1]) begin
              cnt_d   = '0;
              state_d = S_RX_DATA;
            end
`ifdef ETH_CTRL_RX_TIMEOUT_EN
            else if (to_q == 32'(RX_TIMEOUT - 1)) begin
              status_d = 2'd2;
              state_d  = S_DONE;
            end else begin
              to_d = to_q + 32'd1;
            end
`endif
          end
        end
      end
      S_INI_TXN: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_TXN;
        eth_data_in_o = 32'd46;
        state_d       = S_INI_RXN;
      end
      S_INI_RXN: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_RXN;
        eth_data_in_o = 32'd46;
        state_d       = S_DUMMY_WR;
      end
      S_DUMMY_WR: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_DUMMY;
        eth_data_in_o = DUMMY_V;
        state_d       = S_DUMMY_RD;
      end
      S_DUMMY_RD: begin
        if (!ph_q) begin
          eth_sel_o  = 1'b1;
          eth_addr_o = A_DUMMY;
          ph_d       = 1'b1;
        end else begin
          ph_d      = 1'b0;
          init_ok_d = (eth_data_out_i == DUMMY_V);
          status_d  = (eth_data_out_i == DUMMY_V) ? 2'd0 : 2'd1;
          state_d   = S_DONE;
        end
      end
      S_TX_LEN: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_TXN;
        eth_data_in_o = 32'(nb_q);
        cnt_d         = '0;
        state_d       = S_TX_HDR;
      end
      S_TX_HDR: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_DATA + ETH_ADDR_W'(cnt_q);
        eth_data_in_o = {24'h0, hdr_byte(cnt_q[4:0])};
        if (cnt_q == NB_W'(29)) begin
          cnt_d   = '0;
          ph_d    = 1'b0;
          state_d = S_TX_PL;
        end else begin
          cnt_d = cnt_q + NB_W'(1);
        end
      end
      S_TX_PL: begin
        // Address held through both phases so RAM data lines up in phase 1.
        pl_raddr_o = cnt_q;
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          {eth_sel_o, eth_we_o} = 2'b11;
          eth_addr_o    = A_DATA + ETH_ADDR_W'(30) + ETH_ADDR_W'(cnt_q);
          eth_data_in_o = {24'h0, pl_rdata_i};
          ph_d          = 1'b0;
          if (last_byte) state_d = S_TX_GO;
          else           cnt_d   = cnt_q + NB_W'(1);
        end
      end
      S_TX_GO: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_SEND;
        eth_data_in_o = 32'(`ETH_SEND);
        status_d      = 2'd0;
        state_d       = S_DONE;
      end
      S_RX_LEN: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_RXN;
        eth_data_in_o = 32'(nb_q);
        ph_d          = 1'b0;
        state_d       = S_RX_POLL;
      end
      S_RX_DATA: begin
        // Received frame payload starts after the 14-byte MAC header.
        if (!ph_q) begin
          eth_sel_o  = 1'b1;
          eth_addr_o = A_DATA + ETH_ADDR_W'(14) + ETH_ADDR_W'(cnt_q);
          ph_d       = 1'b1;
        end else begin
          pl_we_o    = 1'b1;
          pl_waddr_o = cnt_q;
          pl_wdata_o = eth_data_out_i[7:0];
          ph_d       = 1'b0;
          if (last_byte) state_d = S_RX_ACK;
          else           cnt_d   = cnt_q + NB_W'(1);
        end
      end
      S_RX_ACK: begin
        {eth_sel_o, eth_we_o} = 2'b11;
        eth_addr_o    = A_RCVACK;
        eth_data_in_o = 32'd1;
        status_d      = 2'd0;
        state_d       = S_DONE;
      end
      S_DONE: begin
        done_o   = 1'b1;
        status_o = status_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
